decode_stage: RTL

Parametrised instruction-decode stage for the 5-stage MIPS pipeline, sitting between the fetch stage and the execute stage. It holds the IF/ID pipeline register with stall and flush, a register file with width and depth set by parameters and write-to-read bypass, a load-use hazard detector, and the control decoder. A drain-then-halt state machine replaces delay-based termination and stops the CPU cleanly on the halt word `32'hffffffff`.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/decode_stage_ctrl_decode.sv | 70 +++++++
 rtl/decode_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS decode stage: instruction encodings,
// the halt sentinel, the control bundle and the halt FSM states.
package cpu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    // Instruction word that stops the CPU once older work has retired
    localparam logic [31:0] HALT_WORD = 32'hffff_ffff;

    // Control bundle handed to the execute stage
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       reg_dst;
        logic [5:0] alu_op;
        logic [5:0] alu_funct;
    } ctrl_t;

    // Drain-then-halt state machine
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } halt_state_e;

endpackage

// File: rtl/decode_stage_ctrl_decode.sv
// Pure combinational control decoder: op/funct -> ctrl_t.
// Unrecognised encodings yield an all-zero bundle.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    logic known;

    // Map each supported encoding to its control settings
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ctrl  = '0;
        known = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT,
                    FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SRAV: begin
                        known          = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = 1'b1;
                    end
                    FN_JR: begin
                        known     = 1'b1;
                        ctrl.jump = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                known           = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                known          = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                known          = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                known       = 1'b1;
                ctrl.branch = 1'b1;
            end
            OP_J: begin
                known     = 1'b1;
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                known          = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
        // Raw fields travel only with a recognised instruction
        if (known) begin
            ctrl.alu_op    = op;
            ctrl.alu_funct = funct;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register with stall/flush, register
// file with write-to-read bypass, load-use hazard detection, control decode
// and a drain-then-halt state machine for clean CPU termination.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int TERM_DRAIN = 4,
    parameter int AW         = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            valid_in,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic            flush,
    input  logic            ex_mem_to_reg,
    input  logic [AW-1:0]   ex_rd_addr,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_out,
    output logic            valid_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data,
    output logic [AW-1:0]   rt_addr,
    output logic [AW-1:0]   rd_addr,
    output logic [4:0]      shamt,
    output logic [25:0]     jaddr,
    output logic [XLEN-1:0] imm_sext,
    output logic [XLEN-1:0] imm_zext,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            reg_dst,
    output logic [5:0]      alu_op,
    output logic [5:0]      alu_funct,
    output logic            terminate_out
);

    localparam int CW = (TERM_DRAIN > 1) ? $clog2(TERM_DRAIN) : 1;

    // IF/ID pipeline register
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    // Register file
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    // Halt FSM
    halt_state_e     state_q;
    logic [CW-1:0]   cnt_q;

    logic [AW-1:0]   rs_addr;
    logic            hz;
    logic            halt_in_id;
    logic            issue;
    ctrl_t           ctrl_raw;
    ctrl_t           ctrl_out;

    assign rs_addr = AW'(instr_q[25:21]);
    assign rt_addr = AW'(instr_q[20:16]);
    assign rd_addr = AW'(instr_q[15:11]);
    assign shamt   = instr_q[10:6];
    assign jaddr   = instr_q[25:0];
    assign imm_sext = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
    assign imm_zext = {{(XLEN-16){1'b0}}, instr_q[15:0]};

    // Load-use hazard: a load in EX writes a register this instruction reads
    assign hz = valid_q & ex_mem_to_reg & (ex_rd_addr != '0) &
                ((ex_rd_addr == rs_addr) | (ex_rd_addr == rt_addr));

    // A live halt word in ID stalls fetch right away so nothing younger
    // replaces it; a same-cycle flush squashes it instead.
    assign halt_in_id = (state_q == ST_RUN) & valid_q & ~flush &
                        (instr_q == HALT_WORD);

    assign stall_out     = hz | (state_q != ST_RUN) | halt_in_id;
    assign terminate_out = (state_q == ST_HALT);

    // Only a real, unstalled, non-halt instruction reaches EX
    assign issue     = valid_q & ~hz & (state_q == ST_RUN) & ~halt_in_id;
    assign valid_out = issue;
    assign ctrl_out  = issue ? ctrl_raw : '0;

    assign reg_write    = ctrl_out.reg_write;
    assign mem_to_reg   = ctrl_out.mem_to_reg;
    assign mem_write    = ctrl_out.mem_write;
    assign branch       = ctrl_out.branch;
    assign jump         = ctrl_out.jump;
    assign reg_dst      = ctrl_out.reg_dst;
    assign alu_op       = ctrl_out.alu_op;
    assign alu_funct    = ctrl_out.alu_funct;
    assign pc_plus4_out = pc_q;

    ctrl_decode u_ctrl_decode (
        .op    (instr_q[31:26]),
        .funct (instr_q[5:0]),
        .ctrl  (ctrl_raw)
    );

    // IF/ID next state: flush (ignored once halting) > hold > load
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush && (state_q == ST_RUN)) begin
            instr_d = '0;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (!stall_out) begin
            instr_d = instr_in;
            pc_d    = pc_plus4_in;
            valid_d = valid_in;
        end
    end

    // IF/ID register update
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Register-file next state; register 0 is never written
    always_comb begin
        rf_d = rf_q;
        if (wb_we && (wb_addr != '0)) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Register-file storage
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: clearing every entry on reset makes this a flop array rather than an inferable RAM.
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Operand read with same-cycle write-back bypass; $0 always reads zero
    always_comb begin
        rs_data = rf_q[rs_addr];
        rt_data = rf_q[rt_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_we && (wb_addr == rs_addr)) begin
            rs_data = wb_data;
        end
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_we && (wb_addr == rt_addr)) begin
            rt_data = wb_data;
        end
    end

    // Drain-then-halt FSM: wait TERM_DRAIN cycles after the halt word
    // reaches ID, then park in HALT until reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_in_id) begin
                        if (TERM_DRAIN <= 1) begin
                            state_q <= ST_HALT;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= CW'(TERM_DRAIN - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q <= CW'(1)) begin
                        state_q <= ST_HALT;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_HALT: ;
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
